postprocess_nch: RTL and testbench
==================================

Name: postprocess_nch

Overview:
Parametrised successor to the two-channel requantise-and-packetise stage that sits between the channeliser output and the 10GbE transmit path. It takes N_CH signed spectra, applies a per-channel power-of-two gain, and saturates each sample to OUT_W bits. It packs the results into DATA_W-bit words and emits one framed packet per spectrum: a header word carrying a spectrum counter, followed by the payload words. An arm/sync state machine aligns framing to spectrum boundaries and flags misaligned syncs.

Parameters:
N_CH, 2, number of input channels
IN_W, 24, signed input sample width
OUT_W, 16, signed output sample width (OUT_W < IN_W)
GAIN_W, 5, per-channel gain (left-shift) width
N_SPEC, 2048, bins per spectrum; AW = clog2(N_SPEC)
DATA_W, 64, tx word width; B = DATA_W/(N_CH*OUT_W) bins per word; require B >= 2 and N_SPEC % B == 0

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
arm  in  1  pulse: (re)arm framing to the next sync_in
sync_in  in  1  marks the sample accepted with it as bin 0
ce  in  1  input sample valid
gain  in  N_CH*GAIN_W  channel c gain at [c*GAIN_W +: GAIN_W], unsigned shift
in_data  in  N_CH*IN_W  channel c sample at [c*IN_W +: IN_W], signed
tx_data  out  DATA_W  packet word
tx_valid  out  1  tx_data valid
tx_eof  out  1  last word of packet
addr  out  AW  bin index the next accepted sample will take
ovf  out  N_CH  per-channel saturation pulse
sync_err  out  1  sticky: sync_in seen off a spectrum boundary

Behaviour:
- Reset: all outputs are 0 (tx_data, tx_valid, tx_eof, addr, ovf, sync_err). State is IDLE, spectrum counter is 0, and the pipeline is cleared. A reset mid-packet drops that packet; no eof is emitted.
- A sample is accepted when ce=1. ce=0 stalls the bin counter. Pipeline stages advance every clock.
- FSM transitions:
  - IDLE: arm moves to ARMED.
  - ARMED: when sync_in & ce, that sample is bin 0 and the state moves to RUN.
  - RUN: bin counter increments per accepted sample and wraps at N_SPEC-1 to 0.
- Arm while RUN sets re_arm. At the next wrap (after the packet's eof word is queued) the state moves to ARMED, not bin 0. Arm while ARMED has no effect.
- sync_in is accepted in RUN only when ce=1. If the sample is not bin 0 (counter != 0), sync_err is set sticky, the sync is ignored and framing is unchanged. If the sample is bin 0, no error is raised.
- In IDLE and ARMED, samples are discarded and addr=0. In RUN, addr equals the bin counter.
- Requant (1 registered stage, result at t+1 for acceptance at t):
  - y = (x << gain_c) >>> (IN_W-OUT_W); the shift is arithmetic, i.e. floor.
  - y is computed at full width IN_W + 2^GAIN_W - 1.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - ovf[c]=1 for one cycle (at t+1) when channel c saturated.
- Packing:
  - Bin k of a word occupies lane (k mod B).
  - Lane 0 is the LSBs; within a lane, channel 0 is the LSBs.
  - A word is emitted (tx_valid=1) 2 cycles after acceptance of its last bin.
- Header:
  - Emitted 2 cycles after bin 0 is accepted.
  - tx_data = spectrum counter zero-extended to DATA_W; the counter is DATA_W bits and wraps.
  - B >= 2 guarantees the header never collides with a data word.
- Packet length: 1 header + N_SPEC/B data words. tx_eof=1 only on the last data word.
- The spectrum counter increments when eof is emitted.
- No backpressure: tx_valid must be consumed on the cycle it is asserted.
- tx_eof=0 and tx_data hold their last value whenever tx_valid=0.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately. Release, hold ce=1, no arm -> tx_valid stays 0 and addr=0.
2. Basic framing (N_SPEC=8, gain=0): arm, then sync_in with ce=1 at t0, ch0 bin k = k<<8, ch1 = -(k<<8) -> header 0 at t0+2. Data words follow; word 0 = {16'hFFFF,16'h0001,16'h0000,16'h0000}. 5 words total, eof on word 4; next packet header = 1.
3. Saturation (defaults): 0x7FFFFF g0 -> 0x7FFF, no ovf. 0x7FFFFF g1 -> 0x7FFF, ovf. 0x800000 g0 -> 0x8000, no ovf. 0x800000 g1 -> 0x8000, ovf. 0xFFFFFF g0 -> 0xFFFF. 0xFFFF00 g0 -> 0xFFFF.
4. ce gaps: ce toggled randomly during RUN -> word contents are unchanged from the ce=1 run, each word appears 2 cycles after its last accepted bin, and addr holds during gaps.
5. Sync errors: sync_in at bin 3 -> sync_err=1 (sticky), framing unchanged. Arm at bin 5 -> current packet completes with eof, then the block waits for sync; a sync at a new phase starts header 1 at that phase.
6. Reset mid-packet: rst at bin 4 of packet 2 -> no eof emitted. Re-arm and sync -> header restarts at 0.

Source files
------------

// File: rtl/postprocess_nch.sv
// N-channel requantise-and-packetise stage: per-channel power-of-two gain, saturation,
// lane packing into DATA_W words, and one header-framed packet per spectrum.
module postprocess_nch #(
  parameter int N_CH   = 2,
  parameter int IN_W   = 24,
  parameter int OUT_W  = 16,
  parameter int GAIN_W = 5,
  parameter int N_SPEC = 2048,
  parameter int DATA_W = 64,
  localparam int AW    = $clog2(N_SPEC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     sync_in,
  input  logic                     ce,
  input  logic [N_CH*GAIN_W-1:0]   gain,
  input  logic [N_CH*IN_W-1:0]     in_data,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_valid,
  output logic                     tx_eof,
  output logic [AW-1:0]            addr,
  output logic [N_CH-1:0]          ovf,
  output logic                     sync_err
);

  localparam int LANE_W = N_CH * OUT_W;
  localparam int B      = DATA_W / LANE_W;
  localparam int LW     = (B > 1) ? $clog2(B) : 1;
  localparam int FW     = IN_W + (1 << GAIN_W) - 1;
  localparam int SHR    = IN_W - OUT_W;
  localparam logic signed [FW-1:0] SAT_MAX = {{(FW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [FW-1:0] SAT_MIN = {{(FW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic [AW-1:0]       r_bin;
  logic                r_re_arm;
  logic                w_start, w_take, w_wrap;
  logic [AW-1:0]       w_bin;

  logic signed [FW-1:0] w_x, w_s;
  logic [LANE_W-1:0]   w_lane;
  logic [N_CH-1:0]     w_ovf;

  logic                r_s1_valid, r_s1_first, r_s1_last;
  logic [LW-1:0]       r_s1_lane;
  logic [LANE_W-1:0]   r_s1_samp;
  logic [DATA_W-1:0]   r_pack, w_word, r_spec;

  always_comb begin
    w_start     = (r_state == S_ARMED) && sync_in && ce;
    w_take      = w_start || ((r_state == S_RUN) && ce);
    w_bin       = w_start ? '0 : r_bin;
    w_wrap      = (r_state == S_RUN) && ce && (r_bin == AW'(N_SPEC-1));
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (arm) w_state_nxt = S_ARMED;
      S_ARMED: if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_wrap && (r_re_arm || arm)) w_state_nxt = S_ARMED;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin    <= '0;
      r_re_arm <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (w_take) r_bin <= w_wrap ? '0 : w_bin + 1'b1;
      // A pending re-arm is consumed by the wrap that returns the FSM to ARMED.
      if ((r_state == S_RUN) && (w_state_nxt == S_ARMED)) r_re_arm <= 1'b0;
      else if ((r_state == S_RUN) && arm)                 r_re_arm <= 1'b1;
      if ((r_state == S_RUN) && ce && sync_in && (r_bin != '0)) sync_err <= 1'b1;
    end
  end

  always_comb addr = (r_state == S_RUN) ? r_bin : '0;

  // Full-width shift then floor-divide; saturation judged before truncation.
  always_comb begin
    w_lane = '0;
    w_ovf  = '0;
    w_x    = '0;
    w_s    = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      w_x = FW'($signed(in_data[c*IN_W +: IN_W]));
      w_s = (w_x <<< gain[c*GAIN_W +: GAIN_W]) >>> SHR;
      if (w_s > SAT_MAX) begin
        w_lane[c*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
        w_ovf[c]                 = 1'b1;
      end else if (w_s < SAT_MIN) begin
        w_lane[c*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
        w_ovf[c]                 = 1'b1;
      end else begin
        w_lane[c*OUT_W +: OUT_W] = w_s[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_lane  <= '0;
      r_s1_samp  <= '0;
      ovf        <= '0;
    end else begin
      r_s1_valid <= w_take;
      ovf        <= w_take ? w_ovf : '0;
      if (w_take) begin
        r_s1_samp  <= w_lane;
        r_s1_first <= (w_bin == '0);
        r_s1_last  <= (w_bin == AW'(N_SPEC-1));
        r_s1_lane  <= LW'(w_bin % AW'(B));
      end
    end
  end

  always_comb begin
    w_word = r_pack;
    w_word[int'(r_s1_lane)*LANE_W +: LANE_W] = r_s1_samp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_eof   <= 1'b0;
      r_pack   <= '0;
      r_spec   <= '0;
    end else begin
      tx_valid <= 1'b0;
      tx_eof   <= 1'b0;
      if (r_s1_valid) begin
        r_pack <= w_word;
        if (r_s1_lane == LW'(B-1)) begin
          tx_data  <= w_word;
          tx_valid <= 1'b1;
          tx_eof   <= r_s1_last;
          if (r_s1_last) r_spec <= r_spec + 1'b1;
        end else if (r_s1_first) begin
          tx_data  <= r_spec;
          tx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_postprocess_nch.sv
// Bench for postprocess_nch (N_SPEC=8): behavioural packet model checked every cycle,
// plus directed literal expectations for framing, saturation, re-arm and reset.
module tb_postprocess_nch;

  localparam int NS = 8;
  localparam int B  = 2;

  logic        clk, rst, arm, sync_in, ce;
  logic [9:0]  gain;
  logic [47:0] in_data;
  logic [63:0] tx_data;
  logic        tx_valid, tx_eof;
  logic [2:0]  addr;
  logic [1:0]  ovf;
  logic        sync_err;

  postprocess_nch #(.N_SPEC(NS)) dut (
    .clk(clk), .rst(rst), .arm(arm), .sync_in(sync_in), .ce(ce),
    .gain(gain), .in_data(in_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_eof(tx_eof), .addr(addr), .ovf(ovf), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Requantise one sample: floor((x * 2^g) / 256), clamped to int16; bit 16 flags clamping.
  function automatic logic [16:0] mdl_sat(input logic [23:0] x, input int g);
    longint v, q;
    v = longint'($signed(x)) * (64'sd1 << g);
    q = v / 256;
    if ((v < 0) && (v % 256 != 0)) q = q - 1;
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  // Model: framing flags, bin position, spectrum count, and what the tx port shows next.
  bit          m_armed, m_run, m_rearm, m_err, m_take, m_was_run, m_was_armed;
  int          m_bin, m_k;
  logic [63:0] m_spec = '0;
  logic [63:0] m_tx_d = '0, p_d = '0;
  bit          m_tx_v, m_tx_eof, p_v, p_eof;
  logic [1:0]  m_ovf = '0;
  logic [31:0] m_lanes [B];
  logic [16:0] m_r0, m_r1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_armed = 0; m_run = 0; m_rearm = 0; m_err = 0; m_bin = 0; m_spec = '0;
      m_tx_d = '0; m_tx_v = 0; m_tx_eof = 0; p_v = 0; p_eof = 0; p_d = '0; m_ovf = '0;
    end else begin
      m_tx_v = p_v; m_tx_eof = p_eof;
      if (p_v) m_tx_d = p_d;
      p_v = 0; p_eof = 0; m_ovf = '0;
      m_was_run = m_run; m_was_armed = m_armed; m_take = 0; m_k = 0;
      if (ce && m_was_run) begin
        m_take = 1; m_k = m_bin;
        if (sync_in && m_bin != 0) m_err = 1;
      end else if (ce && sync_in && m_was_armed) begin
        m_take = 1; m_k = 0; m_armed = 0; m_run = 1;
      end
      if (arm && !m_was_run && !m_was_armed) m_armed = 1;
      if (arm && m_was_run) m_rearm = 1;
      if (m_take) begin
        m_r0 = mdl_sat(in_data[23:0],  int'(gain[4:0]));
        m_r1 = mdl_sat(in_data[47:24], int'(gain[9:5]));
        m_ovf = {m_r1[16], m_r0[16]};
        m_lanes[m_k % B] = {m_r1[15:0], m_r0[15:0]};
        if (m_k == 0) begin p_v = 1; p_d = m_spec; end
        if (m_k % B == B-1) begin
          p_v = 1; p_d = {m_lanes[1], m_lanes[0]}; p_eof = (m_k == NS-1);
          if (p_eof) m_spec = m_spec + 1;
        end
        if (m_k == NS-1) begin
          m_bin = 0;
          if (m_rearm) begin m_run = 0; m_armed = 1; m_rearm = 0; end
        end else begin
          m_bin = m_k + 1;
        end
      end
    end
  end

  logic [63:0] dut_log [$];
  bit          eof_log [$];

  always @(negedge clk) begin
    chk("tx_valid", 64'(tx_valid), 64'(m_tx_v));
    chk("tx_eof",   64'(tx_eof),   64'(m_tx_eof));
    chk("tx_data",  tx_data,       m_tx_d);
    chk("addr",     64'(addr),     m_run ? 64'(m_bin) : 64'd0);
    chk("ovf",      64'(ovf),      64'(m_ovf));
    chk("sync_err", 64'(sync_err), 64'(m_err));
    if (tx_valid) begin dut_log.push_back(tx_data); eof_log.push_back(tx_eof); end
  end

  task automatic drive(input bit a, input bit s, input bit c, input logic [47:0] d, input logic [9:0] g);
    @(posedge clk); #1;
    arm = a; sync_in = s; ce = c; in_data = d; gain = g;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1; arm = 0; sync_in = 0; ce = 0; in_data = '0; gain = '0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  function automatic logic [47:0] pk(input int c0, input int c1);
    return {c1[23:0], c0[23:0]};
  endfunction

  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [9:0] rgain();
    return {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
  endfunction

  function automatic logic [63:0] qget(input int i);
    return (dut_log.size() > i) ? dut_log[i] : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  function automatic logic qeof(input int i);
    return (eof_log.size() > i) ? eof_log[i] : 1'bx;
  endfunction

  logic [23:0] s_c0 [8] = '{24'h7FFFFF, 24'h7FFFFF, 24'h800000, 24'h800000,
                            24'hFFFFFF, 24'hFFFF00, 24'h000100, 24'h123456};
  logic [4:0]  s_g0 [8] = '{5'd0, 5'd1, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [1:0]  s_ov [8] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0};

  initial begin
    rst = 1; arm = 0; sync_in = 0; ce = 0; in_data = '0; gain = '0;

    chk("pin_7fffff_g0", 64'(mdl_sat(24'h7FFFFF, 0)), 64'h0_7FFF);
    chk("pin_7fffff_g1", 64'(mdl_sat(24'h7FFFFF, 1)), 64'h1_7FFF);
    chk("pin_800000_g0", 64'(mdl_sat(24'h800000, 0)), 64'h0_8000);
    chk("pin_800000_g1", 64'(mdl_sat(24'h800000, 1)), 64'h1_8000);
    chk("pin_ffffff_g0", 64'(mdl_sat(24'hFFFFFF, 0)), 64'h0_FFFF);
    chk("pin_ffff00_g0", 64'(mdl_sat(24'hFFFF00, 0)), 64'h0_FFFF);

    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Idle: samples with ce=1 (and stray syncs) but no arm produce nothing.
    repeat (8) drive(0, 1'($urandom_range(0, 1)), 1, rnd48(), rgain());
    repeat (2) drive(0, 0, 0, '0, '0);
    chk("idle_valid", 64'(tx_valid), 64'd0);
    chk("idle_addr",  64'(addr),     64'd0);
    chk("idle_log",   64'(dut_log.size()), 64'd0);

    // Basic framing, two packets; sync on the second packet's bin 0 is legal.
    drive(1, 0, 0, '0, '0);
    for (int k = 0; k < NS; k++) drive(0, k == 0, 1, pk(k << 8, -(k << 8)), '0);
    for (int k = 0; k < NS; k++) drive(0, k == 0, 1, pk(k << 8, -(k << 8)), '0);
    repeat (4) drive(0, 0, 0, rnd48(), '0);
    chk("basic_len",   64'(dut_log.size()), 64'd10);
    chk("basic_hdr0",  qget(0), 64'd0);
    chk("basic_word0", qget(1), 64'hFFFF_0001_0000_0000);
    chk("basic_word1", qget(2), 64'hFFFD_0003_FFFE_0002);
    chk("basic_eof3",  64'(qeof(3)), 64'd0);
    chk("basic_eof4",  64'(qeof(4)), 64'd1);
    chk("basic_hdr1",  qget(5), 64'd1);
    chk("basic_noerr", 64'(sync_err), 64'd0);

    // Saturation corners, one packet; ovf pulse checked one edge after each acceptance.
    dut_log.delete(); eof_log.delete();
    for (int i = 0; i < NS; i++) begin
      drive(0, 0, 1, {(i == 6) ? 24'h7FFFFF : 24'h0, s_c0[i]}, {(i == 6) ? 5'd31 : 5'd0, s_g0[i]});
      if (i > 0) chk("sat_ovf", 64'(ovf), 64'(s_ov[i-1]));
    end
    drive(0, 0, 0, '0, '0);
    chk("sat_ovf_last", 64'(ovf), 64'(s_ov[7]));
    repeat (3) drive(0, 0, 0, '0, '0);
    chk("sat_hdr",   qget(0), 64'd2);
    chk("sat_word0", qget(1), 64'h0000_7FFF_0000_7FFF);
    chk("sat_word1", qget(2), 64'h0000_8000_0000_8000);
    chk("sat_word2", qget(3), 64'h0000_FFFF_0000_FFFF);
    chk("sat_word3", qget(4), 64'h0000_1234_7FFF_0001);

    // Same ramp as the basic run with random ce gaps: identical word contents.
    dut_log.delete(); eof_log.delete();
    for (int k = 0; k < NS; k++) begin
      repeat ($urandom_range(0, 2)) drive(0, 0, 0, rnd48(), rgain());
      drive(0, 0, 1, pk(k << 8, -(k << 8)), '0);
    end
    repeat (4) drive(0, 0, 0, rnd48(), '0);
    chk("gap_hdr",   qget(0), 64'd3);
    chk("gap_word0", qget(1), 64'hFFFF_0001_0000_0000);
    chk("gap_word3", qget(4), 64'hFFF9_0007_FFFA_0006);
    chk("gap_eof",   64'(qeof(4)), 64'd1);

    // Random traffic with random ce; the per-cycle model comparison does the work.
    repeat (200) drive(0, 0, 1'($urandom_range(0, 1)), rnd48(), rgain());

    // Misaligned sync, then re-arm mid-packet.
    reset_dut();
    dut_log.delete(); eof_log.delete();
    drive(1, 0, 0, '0, '0);
    drive(0, 1, 1, rnd48(), rgain());
    drive(0, 0, 1, rnd48(), rgain());
    drive(0, 0, 1, rnd48(), rgain());
    drive(0, 1, 1, rnd48(), rgain());
    drive(0, 0, 1, rnd48(), rgain());
    chk("sync_err_set", 64'(sync_err), 64'd1);
    drive(1, 0, 1, rnd48(), rgain());
    drive(0, 0, 1, rnd48(), rgain());
    drive(0, 0, 1, rnd48(), rgain());
    repeat (5) drive(0, 0, 1, rnd48(), rgain());
    chk("armed_addr",   64'(addr), 64'd0);
    chk("rearm_len",    64'(dut_log.size()), 64'd5);
    chk("rearm_hdr0",   qget(0), 64'd0);
    chk("rearm_eof3",   64'(qeof(3)), 64'd0);
    chk("rearm_eof4",   64'(qeof(4)), 64'd1);
    dut_log.delete(); eof_log.delete();
    repeat (2) drive(0, 0, 0, rnd48(), rgain());
    drive(0, 1, 1, rnd48(), rgain());
    for (int k = 1; k <= 4; k++) drive(0, 0, 1, rnd48(), rgain());

    // Asynchronous reset in the middle of packet 2 (just after bin 4 is accepted).
    @(posedge clk); #2;
    chk("phase_hdr1",   qget(0), 64'd1);
    chk("sync_sticky",  64'(sync_err), 64'd1);
    rst = 1; arm = 0; sync_in = 0; ce = 0; in_data = '0; gain = '0;
    #1;
    chk("rst_tx_data",  tx_data,          64'd0);
    chk("rst_tx_valid", 64'(tx_valid),    64'd0);
    chk("rst_tx_eof",   64'(tx_eof),      64'd0);
    chk("rst_addr",     64'(addr),        64'd0);
    chk("rst_ovf",      64'(ovf),         64'd0);
    chk("rst_sync_err", 64'(sync_err),    64'd0);
    dut_log.delete(); eof_log.delete();
    @(posedge clk); #1 rst = 0;
    repeat (4) drive(0, 0, 1, rnd48(), rgain());
    chk("post_rst_quiet", 64'(dut_log.size()), 64'd0);
    drive(1, 0, 0, '0, '0);
    for (int k = 0; k < NS; k++) drive(0, k == 0, 1, rnd48(), rgain());
    repeat (4) drive(0, 0, 0, '0, '0);
    chk("restart_len",  64'(dut_log.size()), 64'd5);
    chk("restart_hdr0", qget(0), 64'd0);
    chk("restart_eof4", 64'(qeof(4)), 64'd1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
